// File: rtl/lm_event_encoder.sv
// lm_event_encoder: coalesces event pulses into bitmap words and queues them in a show-ahead FIFO, with holdoff and a lost-event counter
// ports: clk, rst (sync, active high), events (pulse inputs), rd_en (pop request),
//        rd_data (head word), fifo_empty, fifo_full, pending (captured, not yet pushed), drop_cnt (saturating)
module lm_event_encoder #(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 4,
  parameter int HOLDOFF    = 15,
  parameter int WIDTH_DROP = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      events,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic [WIDTH-1:0]      pending,
  output logic [WIDTH_DROP-1:0] drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = HOLDOFF > 0 ? $clog2(HOLDOFF + 1) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rptr, wptr;
  logic [AW:0]      count;
  logic [HW-1:0]    hcnt;
  logic [WIDTH-1:0] merged;
  logic             pop, push, lost;
  assign merged     = pending | events;
  assign pop        = rd_en && !fifo_empty;
  // a full FIFO still accepts a word when a pop frees a slot in the same cycle
  assign push       = (merged != '0) && (hcnt == '0) && (!fifo_full || pop);
  assign lost       = !push && ((events & pending) != '0);
  assign fifo_empty = count == '0;
  assign fifo_full  = count == (AW+1)'(DEPTH);
  assign rd_data    = mem[rptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      hcnt     <= '0;
      pending  <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= merged;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      count    <= count + (AW+1)'(push) - (AW+1)'(pop);
      pending  <= push ? '0 : merged;
      hcnt     <= push ? HW'(HOLDOFF) : hcnt - HW'(hcnt != '0);
      drop_cnt <= (lost && !(&drop_cnt)) ? drop_cnt + 1'b1 : drop_cnt;
    end
  end
endmodule

// File: tb/tb_lm_event_encoder.sv
// tb_lm_event_encoder: randomized and directed checks of lm_event_encoder against a queue-based model
module tb_lm_event_encoder;
  localparam int W = 4, D = 4, H = 3, WD = 2;
  logic clk = 0, rst = 0, rd_en = 0;
  logic [W-1:0] events = '0;
  logic [W-1:0] rd_data, pending;
  logic fifo_empty, fifo_full;
  logic [WD-1:0] drop_cnt;
  int total = 0, bad = 0;
  int cyc = 0, last_push = -100, drops = 0, pend = 0;
  int q[$];

  lm_event_encoder #(.WIDTH(W), .DEPTH(D), .HOLDOFF(H), .WIDTH_DROP(WD)) dut (
    .clk(clk), .rst(rst), .events(events), .rd_en(rd_en), .rd_data(rd_data),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .pending(pending), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_all();
    chk("empty", fifo_empty, q.size() == 0);
    chk("full", fifo_full, q.size() == D);
    chk("pending", pending, pend);
    chk("drop", drop_cnt, drops);
    if (q.size() > 0) chk("rd_data", rd_data, q[0]);
  endtask

  // one clock: drive inputs, advance the model, check just after the edge
  task automatic step(input int ev, input bit re);
    bit pop, push;
    int merged;
    events = W'(ev);
    rd_en  = re;
    pop    = re && q.size() > 0;
    merged = pend | ev;
    push   = merged != 0 && (cyc - last_push) > H && (q.size() < D || pop);
    if (!push && (ev & pend) != 0 && drops < (1 << WD) - 1) drops++;
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(merged);
      pend = 0;
      last_push = cyc;
    end else pend = merged;
    @(posedge clk);
    #1;
    cyc++;
    check_all();
    @(negedge clk);
  endtask

  task automatic do_reset(input bit re, input int ev);
    rst = 1;
    rd_en = re;
    events = W'(ev);
    @(posedge clk);
    #1;
    rst = 0;
    rd_en = 0;
    events = '0;
    cyc++;
    q.delete();
    pend = 0;
    drops = 0;
    last_push = -100;
    chk("rst_rd_data", rd_data, 0);
    check_all();
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    do_reset(0, 0);
    // single event to FIFO then pop
    step(4'b0010, 0);
    chk("first_word", rd_data, 4'b0010);
    chk("first_empty", fifo_empty, 0);
    step(0, 1);
    chk("pop_empty", fifo_empty, 1);
    // holdoff coalescing
    do_reset(0, 0);
    step(4'b0001, 0);
    step(4'b0100, 0);
    step(0, 0);
    step(4'b1000, 0);
    chk("held", pending, 4'b1100);
    step(0, 0);
    chk("coalesced_pend", pending, 0);
    step(0, 1);
    chk("coalesced_word", rd_data, 4'b1100);
    chk("no_drop", drop_cnt, 0);
    // fill, block, lose, pop-while-full push
    do_reset(0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1 << i, 0);
      repeat (3) step(0, 0);
    end
    chk("filled", fifo_full, 1);
    step(4'b0001, 0);
    chk("blocked", pending, 4'b0001);
    repeat (3) step(0, 0);
    step(4'b0001, 0);
    chk("drop_one", drop_cnt, 1);
    step(0, 1);
    chk("full_push", fifo_full, 1);
    chk("full_push_pend", pending, 0);
    // saturation
    repeat (6) step(4'b0100, 0);
    chk("sat", drop_cnt, 3);
    step(4'b0100, 0);
    chk("sat_hold", drop_cnt, 3);
    // reset while full with pending and rd_en high
    do_reset(1, 4'b1111);
    chk("rst_full", fifo_full, 0);
    // wrap: push/pop pairs
    for (int i = 0; i < 10; i++) begin
      step(1 << (i % W), 0);
      step(0, 1);
      repeat (2) step(0, 0);
    end
    chk("wrap_empty", fifo_empty, 1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset($urandom_range(0, 1), $urandom);
      else step($urandom_range(0, 2) == 0 ? int'($urandom_range(0, 15)) : 0, $urandom_range(0, 3) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
